// File: rtl/render_pkg.sv
// Shared rendering types: screen-space vertex and triangle layouts.
package render_pkg;
    localparam int unsigned COORD_W = 10;

    // [0] = X, [1] = Y
    typedef logic [1:0][COORD_W-1:0] vertex_t;
    typedef vertex_t [2:0] triangle_t;
endpackage

// File: rtl/triangle_queue_if.sv
// Write/read/status bundle between projection, triangle_queue and draw sequencer.
interface triangle_queue_if
    import render_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clear;
    logic             tri_wr;
    triangle_t        tri_in;
    logic             cull_en;
    logic             fifo_r;
    triangle_t        triangle_data;
    logic             fifo_empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [15:0]      culled_cnt;
    logic             overflow;

    modport master (
        output clear, tri_wr, tri_in, cull_en, fifo_r,
        input  triangle_data, fifo_empty, full, count, culled_cnt, overflow
    );

    modport slave (
        input  clear, tri_wr, tri_in, cull_en, fifo_r,
        output triangle_data, fifo_empty, full, count, culled_cnt, overflow
    );
endinterface

// File: rtl/tri_area.sv
// Combinational signed area of a triangle with V0 as origin.
module tri_area
    import render_pkg::*;
(
    input  triangle_t          triangle,
    output logic signed [22:0] area
);
    logic signed [10:0] dx1, dy1, dx2, dy2;
    logic signed [21:0] p_a, p_b;

    always_comb begin
        dx1  = $signed({1'b0, triangle[1][0]}) - $signed({1'b0, triangle[0][0]});
        dy1  = $signed({1'b0, triangle[1][1]}) - $signed({1'b0, triangle[0][1]});
        dx2  = $signed({1'b0, triangle[2][0]}) - $signed({1'b0, triangle[0][0]});
        dy2  = $signed({1'b0, triangle[2][1]}) - $signed({1'b0, triangle[0][1]});
        p_a  = dx1 * dy2;
        p_b  = dx2 * dy1;
        area = $signed({p_a[21], p_a}) - $signed({p_b[21], p_b});
    end
endmodule

// File: rtl/triangle_queue.sv
// Culling triangle FIFO with registered read data (data valid the cycle after fifo_r).
module triangle_queue
    import render_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter bit          CULL_BACK = 1'b0
)(
    input  logic              Clk,
    input  logic              Reset,
    triangle_queue_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    triangle_t          mem [DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count_q;
    logic [15:0]        culled_q;
    logic               overflow_q;
    triangle_t          data_q;

    logic signed [22:0] area;
    logic               is_empty, is_full, cull, rd_ok, wr_ok;

    tri_area u_area (
        .triangle (bus.tri_in),
        .area     (area)
    );

    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CNT_W'(DEPTH));
        cull     = bus.cull_en && ((area == '0) || (CULL_BACK && area < 0));
        rd_ok    = bus.fifo_r && !is_empty;
        wr_ok    = bus.tri_wr && !cull && (!is_full || rd_ok);
    end

    // Storage carries no reset; gating with clear keeps flush cycles side-effect free.
    always_ff @(posedge Clk) begin
        if (wr_ok && !bus.clear && !Reset)
            mem[wptr] <= bus.tri_in;
    end

    always_ff @(posedge Clk) begin
        if (Reset || bus.clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            culled_q   <= '0;
            overflow_q <= 1'b0;
            data_q     <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                data_q <= mem[rptr];
                rptr   <= rptr + 1'b1;
            end
            if (wr_ok && !rd_ok)
                count_q <= count_q + 1'b1;
            else if (rd_ok && !wr_ok)
                count_q <= count_q - 1'b1;
            if (bus.tri_wr && cull && culled_q != '1)
                culled_q <= culled_q + 1'b1;
            if (bus.tri_wr && !cull && !wr_ok)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        bus.triangle_data = data_q;
        bus.fifo_empty    = is_empty;
        bus.full          = is_full;
        bus.count         = count_q;
        bus.culled_cnt    = culled_q;
        bus.overflow      = overflow_q;
    end
endmodule

// File: tb/tb_triangle_queue.sv
// Directed bench for triangle_queue; CULL_BACK=0 and CULL_BACK=1 instances share stimulus.
module tb_triangle_queue;
    import render_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clk = ~Clk;

    triangle_queue_if #(.DEPTH(16)) bus0 ();
    triangle_queue_if #(.DEPTH(16)) bus1 ();

    assign bus1.clear   = bus0.clear;
    assign bus1.tri_wr  = bus0.tri_wr;
    assign bus1.tri_in  = bus0.tri_in;
    assign bus1.cull_en = bus0.cull_en;
    assign bus1.fifo_r  = bus0.fifo_r;

    triangle_queue #(.DEPTH(16), .CULL_BACK(1'b0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    triangle_queue #(.DEPTH(16), .CULL_BACK(1'b1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic triangle_t mk(input int x0, y0, x1, y1, x2, y2);
        triangle_t t;
        t[0][0] = 10'(x0); t[0][1] = 10'(y0);
        t[1][0] = 10'(x1); t[1][1] = 10'(y1);
        t[2][0] = 10'(x2); t[2][1] = 10'(y2);
        return t;
    endfunction

    function automatic triangle_t seq_tri(input int i);
        return mk(i, 0, i + 20, 0, i, 20 + i);
    endfunction

    task automatic push(input triangle_t t, input logic ce);
        bus0.tri_wr = 1'b1; bus0.tri_in = t; bus0.cull_en = ce;
        step();
        bus0.tri_wr = 1'b0; bus0.cull_en = 1'b0;
    endtask

    task automatic pop();
        bus0.fifo_r = 1'b1;
        step();
        bus0.fifo_r = 1'b0;
    endtask

    task automatic pulse_clear();
        bus0.clear = 1'b1;
        step();
        bus0.clear = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " data"},     64'(bus0.triangle_data), 64'd0);
        check({tag, " empty"},    64'(bus0.fifo_empty),    64'd1);
        check({tag, " full"},     64'(bus0.full),          64'd0);
        check({tag, " count"},    64'(bus0.count),         64'd0);
        check({tag, " culled"},   64'(bus0.culled_cnt),    64'd0);
        check({tag, " overflow"}, 64'(bus0.overflow),      64'd0);
    endtask

    initial begin
        triangle_t t_a;
        t_a = mk(0, 0, 10, 0, 0, 10);
        Reset = 1'b1;
        bus0.clear = 1'b0; bus0.tri_wr = 1'b0; bus0.tri_in = '0;
        bus0.cull_en = 1'b0; bus0.fifo_r = 1'b0;
        step(); step();
        Reset = 1'b0;
        check_reset_state("reset");

        // single write then read
        push(t_a, 1'b1);
        check("wr1 count", 64'(bus0.count), 64'd1);
        check("wr1 empty", 64'(bus0.fifo_empty), 64'd0);
        pop();
        check("rd1 count", 64'(bus0.count), 64'd0);
        check("rd1 data",  64'(bus0.triangle_data), 64'(t_a));
        check("rd1 empty", 64'(bus0.fifo_empty), 64'd1);

        // read while empty holds data
        pop();
        check("erd data",     64'(bus0.triangle_data), 64'(t_a));
        check("erd count",    64'(bus0.count), 64'd0);
        check("erd overflow", 64'(bus0.overflow), 64'd0);

        // culling, both polarities
        pulse_clear();
        push(mk(0, 0, 5, 5, 9, 9), 1'b1);
        push(mk(0, 0, 0, 10, 10, 0), 1'b1);
        check("cull0 culled", 64'(bus0.culled_cnt), 64'd1);
        check("cull0 count",  64'(bus0.count), 64'd1);
        check("cull1 culled", 64'(bus1.culled_cnt), 64'd2);
        check("cull1 count",  64'(bus1.count), 64'd0);

        // fill across a pointer wrap
        pulse_clear();
        for (int i = 0; i < 3; i++) push(seq_tri(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            pop();
            check("pre data", 64'(bus0.triangle_data), 64'(seq_tri(100 + i)));
        end
        for (int i = 0; i < 16; i++) push(seq_tri(i), 1'b0);
        check("fill full",  64'(bus0.full), 64'd1);
        check("fill count", 64'(bus0.count), 64'd16);
        check("fill ovf",   64'(bus0.overflow), 64'd0);
        push(seq_tri(50), 1'b0);
        check("ovf flag",  64'(bus0.overflow), 64'd1);
        check("ovf count", 64'(bus0.count), 64'd16);
        bus0.fifo_r = 1'b1;
        push(seq_tri(16), 1'b0);
        bus0.fifo_r = 1'b0;
        check("wr+rd count", 64'(bus0.count), 64'd16);
        check("wr+rd data",  64'(bus0.triangle_data), 64'(seq_tri(0)));
        for (int i = 1; i <= 16; i++) begin
            pop();
            check("drain data", 64'(bus0.triangle_data), 64'(seq_tri(i)));
        end
        check("drain empty", 64'(bus0.fifo_empty), 64'd1);

        // clear beats simultaneous write and read
        pulse_clear();
        push(mk(0, 0, 5, 5, 9, 9), 1'b1);
        for (int i = 0; i < 5; i++) push(seq_tri(200 + i), 1'b0);
        pop();
        check("pre-clr culled", 64'(bus0.culled_cnt), 64'd1);
        bus0.clear = 1'b1; bus0.tri_wr = 1'b1; bus0.fifo_r = 1'b1;
        bus0.tri_in = seq_tri(300);
        step();
        bus0.clear = 1'b0; bus0.tri_wr = 1'b0; bus0.fifo_r = 1'b0;
        check_reset_state("clear");

        // reset mid-stream
        for (int i = 0; i < 4; i++) push(seq_tri(400 + i), 1'b0);
        pop();
        check("pre-rst count", 64'(bus0.count), 64'd3);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset_state("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/triangle_queue.md
# triangle_queue

Triangle buffer between the vertex-projection stage and the triangle draw sequencer. Accepts one screen-space triangle per cycle, optionally culls degenerate or back-facing triangles by signed area, and stores survivors in a circular buffer. The read side is a registered-output FIFO: triangle data appears one cycle after the read strobe, which is the timing the draw sequencer relies on.

## Interface
- DEPTH, 16, number of triangle entries; power of two, at least 2.
- CULL_BACK, 0, 0 culls only zero-area triangles; 1 also culls negative-area (clockwise) triangles.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- clear  in  1  flush pulse: empties the queue and clears status.
- tri_wr  in  1  write strobe for tri_in.
- tri_in  in  [2:0][1:0][9:0]  triangle written; [v][0]=X, [v][1]=Y, unsigned.
- cull_en  in  1  enables area culling on the write path.
- fifo_r  in  1  read strobe from the draw sequencer.
- triangle_data  out  [2:0][1:0][9:0]  registered head triangle, same layout as tri_in.
- fifo_empty  out  1  no stored entries.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  entries stored.
- culled_cnt  out  16  triangles dropped by culling; saturates at 16'hFFFF.
- overflow  out  1  sticky; set when a non-culled write is dropped because the queue is full.

## Operation
- Signed area uses V0 as origin: A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
  - Differences are sign-extended to 11 bits, products are 22 bits, A is 23-bit signed.
  - Computed combinationally in the write cycle.
- Cull condition: cull_en && (A == 0 || (CULL_BACK && A < 0)).
  - A culled write never touches storage or count, even when the queue is full.
  - A culled write increments culled_cnt.
- Write acceptance: tri_wr && !cull && (!full || rd_ok).
  - rd_ok = fifo_r && !fifo_empty.
  - When the queue is full, a write is accepted only if a valid read happens in the same cycle.
  - Otherwise the write is dropped and overflow is set.
- Read: if rd_ok, triangle_data is loaded from mem[rptr] at the clock edge and rptr advances.
  - If fifo_r is asserted while empty, it is ignored: triangle_data holds and no flag is set.
- Count update:
  - Accepted write only: count +1.
  - Valid read only: count -1.
  - Both in the same cycle: count unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally; full and fifo_empty are derived from count.
- clear takes priority over tri_wr and fifo_r in the same cycle. It zeroes pointers, count, overflow, culled_cnt and triangle_data. Storage contents are don't-care.
- Reset has the same effect as clear.

## Timing
- Reset values: triangle_data=0, fifo_empty=1, full=0, count=0, culled_cnt=0, overflow=0.
- Write-to-visibility latency: an accepted write in cycle N updates count, fifo_empty and full after edge N.
- Read latency: fifo_r sampled at edge N gives the new triangle_data valid from cycle N+1 and held until the next valid read.
  - The sequencer strobes in one state and latches in the next; that latch must see the popped entry.
- A write into an empty queue in cycle N may be read in cycle N+1. There is no bypass in cycle N.
- All status outputs are registered or decoded from registered count only; no combinational path from inputs to outputs.

## Structure
- The shared package `render_pkg` holds:
  - typedef vertex_t = logic [1:0][9:0];
  - typedef triangle_t = vertex_t [2:0];
  - constant COORD_W = 10.
- Sub-module `tri_area`: purely combinational. Takes a triangle_t and returns the 23-bit signed area. It is reused later by the rasteriser's edge setup.
- Storage is an inferred register array of triangle_t [DEPTH], written synchronously with no reset.

## Test plan
- Reset, then write (0,0),(10,0),(0,10) with cull_en=1 (A=+100), then strobe fifo_r one cycle later.
  - count goes 1 then 0; triangle_data equals that triangle the cycle after fifo_r.
  - fifo_empty returns to 1.
- cull_en=1, CULL_BACK=0: write collinear (0,0),(5,5),(9,9), then reversed winding (0,0),(0,10),(10,0) (A=-100).
  - The first is dropped and culled_cnt=1; the second is stored and count=1.
  - Repeat with CULL_BACK=1: both are dropped and culled_cnt=2.
- Write DEPTH=16 distinct triangles: full=1.
  - A 17th write alone sets overflow and leaves count=16.
  - A 17th write with a simultaneous fifo_r is accepted and count stays 16.
  - Reads return all entries in write order across the pointer wrap.
- Strobe fifo_r while empty, holding prior data T: triangle_data remains T, count remains 0, overflow remains 0.
- Fill 5 entries and pulse clear together with tri_wr and fifo_r.
  - Next cycle: count=0, fifo_empty=1, triangle_data=0, culled_cnt=0, overflow=0.
- Assert Reset for one cycle mid-stream with 3 entries queued: all outputs return to their reset values on the following cycle.
